// File: rtl/m10k_responder.sv
// m10k_responder: slave side of the M10K read/write interface.
// Serves reads and byte-masked writes from an inferred single-port block RAM.
// After reset it can zero the whole array. Reads return after a fixed
// READ_LATENCY of 1 or 2 cycles, each with a readdatavalid strobe.
// A request that asserts read and write together sets a sticky protocol_err.
// Optional macro M10K_RESPONDER_RDW_BYPASS_EN makes a same-cycle read+write
// legal. In that case the read returns the freshly written (merged) word.
module m10k_responder #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 2,
    parameter int INIT_CLEAR   = 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                chipselect,
    input  logic                read,
    input  logic                write,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W/8-1:0] byteenable,
    input  logic [DATA_W-1:0]   writedata,
    output logic                waitrequest,
    output logic [DATA_W-1:0]   readdata,
    output logic                readdatavalid,
    output logic                protocol_err
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int BE_W  = DATA_W / 8;

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

`ifdef M10K_RESPONDER_RDW_BYPASS_EN
    localparam logic RDW_OK = 1'b1;
`else
    localparam logic RDW_OK = 1'b0;
`endif

    logic [0:0]          state;
    logic [ADDR_W-1:0]   init_cnt;
    logic                ready;
    logic                acc_wr, acc_rd, rw_err;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wd;
    logic [BE_W-1:0]     mem_be;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   ram_q;
    logic [DATA_W-1:0]   rd_word;
    logic [READ_LATENCY:1] vld_pipe;

    assign ready       = (state == ST_READY);
    assign waitrequest = ~ready;

    // Request qualification. Read and write share the single address port,
    // so a simultaneous pair always targets the same word.
    assign acc_wr = ready & chipselect & write;
    assign acc_rd = ready & chipselect & read & (~write | RDW_OK);
    assign rw_err = ready & chipselect & read & write & ~RDW_OK;

    // The clear sequence owns the write port while in INIT.
    always_comb begin
        mem_we   = acc_wr;
        mem_addr = address;
        mem_wd   = writedata;
        mem_be   = byteenable;
        if (!ready) begin
            mem_we   = 1'b1;
            mem_addr = init_cnt;
            mem_wd   = '0;
            mem_be   = '1;
        end
    end

    // Init/ready control: sweep every word once, then accept traffic.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= (INIT_CLEAR != 0) ? ST_INIT : ST_READY;
            init_cnt <= '0;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + 1'b1;
            if (&init_cnt) state <= ST_READY;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)    protocol_err <= 1'b0;
        else if (rw_err) protocol_err <= 1'b1;
    end

    // RAM write port with byte masking. There is no reset here, so this infers block RAM.
    always_ff @(posedge clock) begin
        for (int b = 0; b < BE_W; b++)
            if (mem_we && mem_be[b]) mem[mem_addr][b*8 +: 8] <= mem_wd[b*8 +: 8];
    end

    // Synchronous read. On a same-cycle write this captures the old word.
    // It only loads on accepted reads, so it holds between responses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)    ram_q <= '0;
        else if (acc_rd) ram_q <= mem[address];
    end

`ifdef M10K_RESPONDER_RDW_BYPASS_EN
    logic              byp_hit;
    logic [DATA_W-1:0] byp_wd;
    logic [BE_W-1:0]   byp_be;

    // Remember the write that coincided with the read, to merge it into the old word.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            byp_hit <= 1'b0;
            byp_wd  <= '0;
            byp_be  <= '0;
        end else if (acc_rd) begin
            byp_hit <= acc_wr;
            byp_wd  <= writedata;
            byp_be  <= byteenable;
        end
    end

    // Bypass mux: written bytes come from the write, others from the RAM.
    always_comb begin
        rd_word = ram_q;
        if (byp_hit)
            for (int b = 0; b < BE_W; b++)
                if (byp_be[b]) rd_word[b*8 +: 8] = byp_wd[b*8 +: 8];
    end
`else
    assign rd_word = ram_q;
`endif

    // Read valid shift register. There is one stage per cycle of latency.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= acc_rd;
            for (int i = 2; i <= READ_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    assign readdatavalid = vld_pipe[READ_LATENCY];

    generate
        if (READ_LATENCY == 2) begin : g_outreg
            logic [DATA_W-1:0] rdata_q;
            // Output register stage. It holds the last response while idle.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n)         rdata_q <= '0;
                else if (vld_pipe[1]) rdata_q <= rd_word;
            end
            assign readdata = rdata_q;
        end else begin : g_direct
            assign readdata = rd_word;
        end
    endgenerate

endmodule

// File: tb/tb_m10k_responder.sv
// Directed bench for m10k_responder in its default configuration.
// A scoreboard queue holds the expected read responses and their due cycles.
// It also follows M10K_RESPONDER_RDW_BYPASS_EN if that macro is defined.
module tb_m10k_responder;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        chipselect = 1'b0, read = 1'b0, write = 1'b0;
    logic [7:0]  address = '0;
    logic [3:0]  byteenable = '0;
    logic [31:0] writedata = '0;
    logic        waitrequest, readdatavalid, protocol_err;
    logic [31:0] readdata;

    m10k_responder dut (
        .clock(clock), .reset_n(reset_n), .chipselect(chipselect), .read(read),
        .write(write), .address(address), .byteenable(byteenable),
        .writedata(writedata), .waitrequest(waitrequest), .readdata(readdata),
        .readdatavalid(readdatavalid), .protocol_err(protocol_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] d;
        int          due;
    } exp_t;

    exp_t        q[$];
    logic [31:0] model [256];
    int          cyc = 0;
    int          n_pass = 0, n_total = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
    endtask

    task automatic mwrite(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        for (int b = 0; b < 4; b++)
            if (be[b]) model[a][b*8 +: 8] = d[b*8 +: 8];
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        chipselect = 1'b1; read = 1'b0; write = 1'b1;
        address = a; writedata = d; byteenable = be;
        mwrite(a, d, be);
        tick();
    endtask

    task automatic rd(input logic [7:0] a);
        chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
        q.push_back(exp_t'{model[a], cyc + 2});
        tick();
    endtask

    // Simultaneous read+write: it is illegal by default, and a bypassed read with the macro.
    task automatic rdwr(input logic [7:0] a, input logic [31:0] d);
        chipselect = 1'b1; read = 1'b1; write = 1'b1;
        address = a; writedata = d; byteenable = 4'hF;
        mwrite(a, d, 4'hF);
`ifdef M10K_RESPONDER_RDW_BYPASS_EN
        q.push_back(exp_t'{model[a], cyc + 2});
`endif
        tick();
        idle();
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while (q.size() != 0 && k < 20) begin
            tick();
            k++;
        end
        repeat (2) tick();
        chk(tag, 32'(q.size()), 32'd0);
    endtask

    task automatic wait_init(input string tag);
        int k = 0;
        while (waitrequest && k < 400) begin
            tick();
            k++;
        end
        chk(tag, 32'(k), 32'd256);
        for (int i = 0; i < 256; i++) model[i] = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rdata"}, readdata, 32'h0);
        chk({tag, "_rdv"}, {31'b0, readdatavalid}, 32'h0);
        chk({tag, "_err"}, {31'b0, protocol_err}, 32'h0);
        chk({tag, "_wait"}, {31'b0, waitrequest}, 32'h1);
    endtask

    // Response monitor. It samples on the falling edge and checks both the data and the exact cycle.
    always @(negedge clock) begin
        if (readdatavalid) begin
            if (q.size() == 0) begin
                chk("unexpected_rdv", 32'h1, 32'h0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rdata", readdata, e.d);
                chk("rd_cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    initial begin
        // Power-on reset.
        repeat (3) tick();
        chk_reset_outputs("por");
        reset_n = 1'b1;
        wait_init("init_len");

        // Cleared words at the bottom, middle and top of the array.
        rd(8'h00); rd(8'h7F); rd(8'hFF); idle();
        drain("init_reads");

        // Byte-masked write.
        wr(8'h10, 32'hDEADBEEF, 4'hF);
        wr(8'h10, 32'h11223344, 4'h5);
        idle(); tick();
        chk("be_model", model[8'h10], 32'hDE22BE44);
        rd(8'h10); idle();
        drain("be_read");

        // A byteenable of 0 leaves the word unchanged.
        wr(8'h10, 32'hFFFFFFFF, 4'h0); idle();
        rd(8'h10); idle();
        drain("be_zero");

        // Streaming reads, one per cycle, returned in order.
        for (int k = 0; k < 8; k++) wr(8'(k), 32'h10 + 32'(k), 4'hF);
        for (int k = 0; k < 8; k++) rd(8'(k));
        idle();
        drain("stream");

        // A read without chipselect is ignored and raises no error.
        chipselect = 1'b0; read = 1'b1; address = 8'h05; tick(); idle();
        repeat (3) tick();
        chk("no_cs_err", {31'b0, protocol_err}, 32'h0);

        // Protocol error: read and write together.
        rdwr(8'h20, 32'hCAFEF00D);
        drain("proto_drain");
`ifdef M10K_RESPONDER_RDW_BYPASS_EN
        chk("proto_err", {31'b0, protocol_err}, 32'h0);
`else
        chk("proto_err", {31'b0, protocol_err}, 32'h1);
`endif
        rd(8'h20); idle();
        drain("proto_readback");

        // Read-during-write on a zeroed word.
        chk("rdw_pre", model[8'h30], 32'h0);
        rdwr(8'h30, 32'hAABBCCDD);
        drain("rdw_drain");
`ifdef M10K_RESPONDER_RDW_BYPASS_EN
        chk("rdw_err", {31'b0, protocol_err}, 32'h0);
`else
        chk("rdw_err", {31'b0, protocol_err}, 32'h1);
`endif
        rd(8'h30); idle();
        drain("rdw_readback");
`ifndef M10K_RESPONDER_RDW_BYPASS_EN
        chk("err_sticky", {31'b0, protocol_err}, 32'h1);
`endif

        // Reset mid-stream: two reads in flight, then a one-cycle reset.
        rd(8'h10);
        chipselect = 1'b1; read = 1'b1; write = 1'b0; address = 8'h11;
        @(negedge clock);
        reset_n = 1'b0;
        idle();
        q.delete();
        tick();
        chk_reset_outputs("mid_rst");
        reset_n = 1'b1;
        wait_init("reinit_len");
        rd(8'h10); idle();
        drain("reinit_clear");
        chk("err_after_rst", {31'b0, protocol_err}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
